// File: rtl/aes_uart_pkg.sv
// Widths shared between the UART receive path and the AES core.
package aes_uart_pkg;
    localparam int AES_BLOCK_W     = 128;
    localparam int UART_BYTE_W     = 8;
    localparam int AES_BLOCK_BYTES = 16;
endpackage

// File: rtl/block_hold_reg.sv
// Output register for one assembled block with a valid/ready handshake.
module block_hold_reg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         free
);
    // The register can take a new block when empty or when being drained now.
    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/sipo_block_packer.sv
// Packs a word stream into wide blocks; one block assembles while the previous one waits.
module sipo_block_packer
    import aes_uart_pkg::*;
#(
    parameter int DATA_W    = UART_BYTE_W,
    parameter int WORDS     = AES_BLOCK_BYTES,
    parameter int MSB_FIRST = 1,
    localparam int OUT_W    = DATA_W * WORDS,
    localparam int CNT_W    = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  fill_count
);
    logic [OUT_W-1:0] asm_data;
    logic [OUT_W-1:0] asm_next;
    logic [CNT_W-1:0] fill_next;
    logic             accept;
    logic             last_word;
    logic             asm_full;
    logic             hold_free;
    logic             load;

    assign asm_full  = (fill_count == CNT_W'(WORDS));
    assign in_ready  = reset && !clear && !asm_full;
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (fill_count == CNT_W'(WORDS - 1));
    // A full assembly register has no matching slot, so asm_next equals asm_data then.
    assign load      = hold_free && (last_word || (asm_full && !clear));

    always_comb begin
        asm_next = asm_data;
        if (accept) begin
            for (int w = 0; w < WORDS; w++) begin
                if (fill_count == CNT_W'(w)) begin
                    if (MSB_FIRST != 0)
                        asm_next[OUT_W-1-w*DATA_W -: DATA_W] = in_data;
                    else
                        asm_next[w*DATA_W +: DATA_W] = in_data;
                end
            end
        end
    end

    always_comb begin
        fill_next = fill_count;
        if (clear)
            fill_next = '0;
        else if (last_word)
            fill_next = hold_free ? '0 : CNT_W'(WORDS);
        else if (accept)
            fill_next = fill_count + CNT_W'(1);
        else if (asm_full && hold_free)
            fill_next = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_count <= '0;
            asm_data   <= '0;
        end else begin
            fill_count <= fill_next;
            asm_data   <= asm_next;
        end
    end

    block_hold_reg #(.W(OUT_W)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (asm_next),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .free      (hold_free)
    );
endmodule

// File: tb/tb_sipo_block_packer.sv
// Directed and randomized checks of sipo_block_packer in both byte orders.
module tb_sipo_block_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         clear = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, in_ready_l;
    logic [127:0] out_data, out_data_l;
    logic         out_valid, out_valid_l;
    logic [4:0]   fill_count, fill_count_l;

    int checks = 0;
    int fails  = 0;

    logic [7:0] seq [16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                             8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
    localparam logic [127:0] BLK_MSB = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] BLK_LSB = 128'h1032547698BADCFEEFCDAB8967452301;
    localparam logic [127:0] BLK_B   = 128'h00112233445566778899AABBCCDDEEFF;

    always #5 clk = ~clk;

    sipo_block_packer #(.DATA_W(8), .WORDS(16), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fill_count(fill_count)
    );

    sipo_block_packer #(.DATA_W(8), .WORDS(16), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .clear(clear), .out_data(out_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .fill_count(fill_count_l)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    initial begin
        logic [127:0] q_msb[$];
        logic [127:0] q_lsb[$];
        logic [127:0] cur_msb, cur_lsb;
        int acc_words, got_blocks, cycles;
        logic acc, hand;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_fill", 128'(fill_count), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        reset = 1'b1;
        #1;
        chk("in_ready_after_rst", 128'(in_ready), 128'(1));

        // Back-to-back stream, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(seq[i]);
            if (i == 14) chk("no_early_valid", 128'(out_valid), 128'(0));
        end
        in_valid = 1'b0;
        chk("blk_valid", 128'(out_valid), 128'(1));
        chk("blk_msb", out_data, BLK_MSB);
        chk("blk_lsb", out_data_l, BLK_LSB);
        chk("blk_fill", 128'(fill_count), 128'(0));
        tick();
        chk("valid_one_cycle", 128'(out_valid), 128'(0));

        // Backpressure: two blocks buffered
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(seq[i]);
        chk("bp_blk1_valid", 128'(out_valid), 128'(1));
        for (int i = 0; i < 16; i++) send(8'(i * 17));
        in_valid = 1'b0;
        chk("bp_fill_full", 128'(fill_count), 128'(16));
        chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        chk("bp_blk1_held", out_data, BLK_MSB);
        tick();
        chk("bp_blk1_stable", out_data, BLK_MSB);
        chk("bp_still_full", 128'(fill_count), 128'(16));
        out_ready = 1'b1;
        tick();
        chk("bp_blk2_valid", 128'(out_valid), 128'(1));
        chk("bp_blk2_data", out_data, BLK_B);
        chk("bp_fill_zero", 128'(fill_count), 128'(0));
        chk("bp_in_ready_back", 128'(in_ready), 128'(1));
        tick();
        chk("bp_drained", 128'(out_valid), 128'(0));

        // Partial block then clear
        for (int i = 0; i < 5; i++) send(seq[i]);
        chk("clr_fill5", 128'(fill_count), 128'(5));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        chk("clr_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_fill0", 128'(fill_count), 128'(0));
        chk("clr_no_valid", 128'(out_valid), 128'(0));
        for (int i = 0; i < 16; i++) send(seq[i]);
        in_valid = 1'b0;
        chk("clr_blk_valid", 128'(out_valid), 128'(1));
        chk("clr_blk_data", out_data, BLK_MSB);
        tick();

        // Reset mid-block while a block is held
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(seq[i]);
        for (int i = 0; i < 7; i++) send(seq[i]);
        in_valid = 1'b0;
        chk("mid_fill7", 128'(fill_count), 128'(7));
        chk("mid_valid", 128'(out_valid), 128'(1));
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_data", out_data, 128'(0));
        chk("mid_rst_fill", 128'(fill_count), 128'(0));
        reset = 1'b1;

        // Random gaps and backpressure over 100 blocks
        acc_words  = 0;
        got_blocks = 0;
        cycles     = 0;
        cur_msb    = '0;
        cur_lsb    = '0;
        while (got_blocks < 100 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc  = in_valid && in_ready;
            hand = out_valid && out_ready;
            if (hand) begin
                if (q_msb.size() == 0) begin
                    chk("rnd_unexpected_block", out_data, 128'(0) - 1);
                end else begin
                    chk("rnd_blk_msb", out_data, q_msb.pop_front());
                    chk("rnd_blk_lsb", out_data_l, q_lsb.pop_front());
                end
                got_blocks++;
            end
            if (acc) begin
                cur_msb = {cur_msb[119:0], in_data};
                cur_lsb = {in_data, cur_lsb[127:8]};
                acc_words++;
                if (acc_words % 16 == 0) begin
                    q_msb.push_back(cur_msb);
                    q_lsb.push_back(cur_lsb);
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("rnd_budget", 128'(cycles < 20000), 128'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid) begin
                if (q_msb.size() != 0) chk("rnd_drain_blk", out_data, q_msb.pop_front());
                got_blocks++;
            end
            tick();
        end
        chk("rnd_no_loss", 128'(got_blocks), 128'(acc_words / 16));
        chk("rnd_queue_empty", 128'(q_msb.size()), 128'(0));
        chk("rnd_fill_mod", 128'(fill_count), 128'(acc_words % 16));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/sipo_block_packer.md
# sipo_block_packer

Parametrised serial-in/parallel-out block packer with valid/ready handshakes on both sides. Collects `WORDS` words of `DATA_W` bits from the UART receive path into one `DATA_W*WORDS`-bit block (default 16 × 8 = 128-bit AES block) and presents it to the AES core. Double-buffered: the next block assembles while the previous one waits for the consumer. Adds selectable byte order, a partial-block clear and a fill count.

## Interface
- `DATA_W`, 8, width of one input word; ≥ 1.
- `WORDS`, 16, words per block; ≥ 1.
- `MSB_FIRST`, 1, 1 = first word lands in the top bits of the block; 0 = first word lands in the bottom bits.
- `OUT_W` (localparam), `DATA_W*WORDS`, block width.
- `CNT_W` (localparam), `$clog2(WORDS+1)`, fill count width.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_data`  in  DATA_W  input word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  packer accepts a word this cycle.
- `clear`  in  1  synchronous discard of the partial block being assembled.
- `out_data`  out  OUT_W  assembled block.
- `out_valid`  out  1  `out_data` holds a complete block.
- `out_ready`  in  1  consumer takes the block this cycle.
- `fill_count`  out  CNT_W  words held in the assembly register (0..WORDS).

## Operation
- Accept: `in_valid && in_ready`. Handoff: `out_valid && out_ready`.
- Word index k = `fill_count` at accept time.
  - `MSB_FIRST=1`: word k is written to `[OUT_W-1-k*DATA_W -: DATA_W]`.
  - `MSB_FIRST=0`: word k is written to `[k*DATA_W +: DATA_W]`.
- Assembly register: counter `fill_count` plus a data register. The output register holds `out_data`/`out_valid`.
- Output register is free when `!out_valid || out_ready`.
- Accept of word k < WORDS-1: `fill_count` increments.
- Accept of word WORDS-1:
  - if the output register is free, the block (including this word) loads into the output register, `out_valid`=1 and `fill_count`=0 on the next edge;
  - otherwise `fill_count` becomes WORDS (assembly full).
- Assembly full (`fill_count==WORDS`): `in_ready`=0. On the first free cycle the assembly block transfers to the output register, `out_valid` stays 1 with the new data, and `fill_count` becomes 0.
- `in_ready = reset && !clear && (fill_count != WORDS)`. Combinational from state and `clear` only, never from `in_valid`.
- `clear`=1: `fill_count`→0 on the next edge, and no word is accepted in that cycle. The output register is untouched, and a full assembly block is discarded.
- Simultaneous handoff and load: the new block replaces the old one with no bubble; `out_valid` does not drop.
- `out_data` is stable while `out_valid && !out_ready`.
- Unwritten assembly bits are don't-care; every emitted block has all WORDS positions written after its last clear or reset.
- `WORDS=1`: every accept forms a block.

## Timing
- Reset values (`reset`=0 at an edge): `out_valid`=0, `out_data`=0, `fill_count`=0, assembly data=0. `in_ready`=0 while `reset` is low.
- Reset mid-block or mid-handoff discards everything on that edge.
- Latency: `out_valid` rises one cycle after the accept of the last word. Throughput is one word per cycle sustained when `out_ready`=1.
- Backpressure: with `out_ready` held 0, up to 2 blocks are buffered (1 in the output register, 1 in assembly). `in_ready` falls the cycle after the 2·WORDS-th accept.
- After `out_ready` rises: the next block is visible one cycle later, and `in_ready` returns in the same cycle the transfer completes.
- No combinational path from `out_ready` to `in_ready`. Freeing the assembly register takes one edge.

## Structure
- Shared package `aes_uart_pkg`: `AES_BLOCK_W=128`, `UART_BYTE_W=8`, `AES_BLOCK_BYTES=16`. These are used as the parameter defaults of this block.
- One sub-module: `block_hold_reg`, the OUT_W-wide valid/ready output register with load and handoff. The assembly counter and datapath stay in the top module.

## Test plan
- Default params, reset, then bytes 01,23,45,67,89,AB,CD,EF,FE,DC,BA,98,76,54,32,10 back-to-back with `out_ready`=1 -> `out_valid`=1 for exactly one cycle, one cycle after the 16th accept; `out_data`=0123456789ABCDEFFEDCBA9876543210.
- `MSB_FIRST=0`, same stream -> `out_data`=1032547698BADCFEEFCDAB8967452301.
- `out_ready`=0, 32 bytes streamed -> block 1 held stable; `fill_count`=16 and `in_ready`=0 after the 32nd accept. Raise `out_ready` for 2 cycles -> block 1, then block 2, with no `out_valid` gap; `fill_count`=0 and `in_ready`=1.
- 5 bytes, then `clear` for 1 cycle with `in_valid`=1 -> that byte is not accepted, `fill_count`=0, `out_valid` stays 0. The next 16 bytes produce a correct block.
- `reset` low after 7 bytes while `out_valid`=1 -> next cycle `out_valid`=0, `out_data`=0, `fill_count`=0.
- Random `in_valid` gaps and random `out_ready` over 100 blocks -> every block matches the scoreboard in order; no loss or duplication; `fill_count` equals accepts mod block.
